conf_slave_sram_like: RTL and testbench

Responder end of the sram_like data interface: accepts one transaction at a time from the uncached-data initiator, applies a configurable response latency, and serves a small bank of peripheral registers. These are LED, switch, seven-segment number, scratch and free-running timer. It sits in the SoC between the CPU-side data bridge's conf_data_* port and the board I/O pins.

---
 rtl/conf_slave_sram_like_if.sv | 21 ++
 rtl/conf_slave_sram_like.sv | 141 ++++++++++++++
 tb/tb_conf_slave_sram_like.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conf_slave_sram_like_if.sv
// rtl/conf_slave_sram_like_if.sv - sram_like conf_data bus between the uncached-data initiator and its responder
interface conf_slave_sram_like_if;
  logic        conf_data_req;
  logic        conf_data_wr;
  logic [1:0]  conf_data_size;
  logic [31:0] conf_data_addr;
  logic [31:0] conf_data_wdata;
  logic [31:0] conf_data_rdata;
  logic        conf_data_addr_ok;
  logic        conf_data_data_ok;

  modport master (
    output conf_data_req, conf_data_wr, conf_data_size, conf_data_addr, conf_data_wdata,
    input  conf_data_rdata, conf_data_addr_ok, conf_data_data_ok
  );

  modport slave (
    input  conf_data_req, conf_data_wr, conf_data_size, conf_data_addr, conf_data_wdata,
    output conf_data_rdata, conf_data_addr_ok, conf_data_data_ok
  );
endinterface

// File: rtl/conf_slave_sram_like.sv
// rtl/conf_slave_sram_like.sv - sram_like responder with fixed response latency and LED/switch/NUM/scratch/timer registers
// Define CONF_TIMER_EN to build the free-running TIMER register at 0xE000.
module conf_slave_sram_like #(
  parameter int          RESP_LAT  = 2,
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  conf_slave_sram_like_if.slave  bus,
  input  logic [15:0]            switch,
  output logic [15:0]            led,
  output logic [31:0]            num_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0]  CNT_LOAD  = 4'(RESP_LAT - 1);
  localparam logic [13:0] A_LED     = 14'h3C00;
  localparam logic [13:0] A_SWITCH  = 14'h3C01;
  localparam logic [13:0] A_NUM     = 14'h3C02;
  localparam logic [13:0] A_SCRATCH = 14'h3C03;
  localparam logic [13:0] A_TIMER   = 14'h3800;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept, wr_en;
  logic [3:0]  be;
  logic [13:0] word_addr;
  logic [31:0] rd_val, rdata_q, scratch, led_new;
  logic        unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] en);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = en[i] ? nw[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

  // Decode on word address so sub-word accesses to any lane hit the same register.
  assign word_addr = bus.conf_data_addr[15:2];
  assign accept    = (state == S_IDLE) && bus.conf_data_req;
  assign wr_en     = accept && bus.conf_data_wr;
  assign led_new   = merge({16'h0, led}, bus.conf_data_wdata, be);

  always_comb begin
    be = 4'b0000;
    case (bus.conf_data_size)
      2'b00:   be[bus.conf_data_addr[1:0]] = 1'b1;
      2'b01:   be = bus.conf_data_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

`ifdef CONF_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= TIMER_RST;
    end else if (wr_en && word_addr == A_TIMER) begin
      timer <= merge(timer, bus.conf_data_wdata, be);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  assign unused_bits = ^{bus.conf_data_addr[31:16], led_new[31:16]};
`else
  assign unused_bits = ^{bus.conf_data_addr[31:16], led_new[31:16], TIMER_RST};
`endif

  always_comb begin
    rd_val = 32'h0;
    case (word_addr)
      A_LED:     rd_val = {16'h0, led};
      A_SWITCH:  rd_val = {16'h0, switch};
      A_NUM:     rd_val = num_data;
      A_SCRATCH: rd_val = scratch;
`ifdef CONF_TIMER_EN
      A_TIMER:   rd_val = timer;
`endif
      default:   rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= 32'h0;
      led      <= 16'h0;
      num_data <= 32'h0;
      scratch  <= 32'h0;
    end else if (accept) begin
      rdata_q <= rd_val;
      if (bus.conf_data_wr) begin
        case (word_addr)
          A_LED:     led      <= led_new[15:0];
          A_NUM:     num_data <= merge(num_data, bus.conf_data_wdata, be);
          A_SCRATCH: scratch  <= merge(scratch, bus.conf_data_wdata, be);
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // WAIT lasts RESP_LAT-1 cycles so DONE follows edge E0+RESP_LAT-1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.conf_data_req) begin
          cnt_next   = CNT_LOAD;
          state_next = (RESP_LAT <= 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.conf_data_addr_ok = (state == S_IDLE);
  assign bus.conf_data_data_ok = (state == S_DONE);
  assign bus.conf_data_rdata   = rdata_q;

endmodule

// File: tb/tb_conf_slave_sram_like.sv
// tb/tb_conf_slave_sram_like.sv - vector table, corner sequences and random traffic against a register-map model
module tb_conf_slave_sram_like;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw  = 16'h0;
  logic [15:0] led_a, led_b;
  logic [31:0] num_a, num_b;

  conf_slave_sram_like_if ifa ();
  conf_slave_sram_like_if ifb ();

  conf_slave_sram_like #(.RESP_LAT(2), .TIMER_RST(32'h0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .switch(sw), .led(led_a), .num_data(num_a));
  conf_slave_sram_like #(.RESP_LAT(1), .TIMER_RST(32'h0000_1000)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .switch(sw), .led(led_b), .num_data(num_b));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_led [2];
  logic [31:0] m_num [2];
  logic [31:0] m_scr [2];
  logic [31:0] m_tbase [2];
  int unsigned m_tcyc [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic aok(input int d);
    return (d == 0) ? ifa.conf_data_addr_ok : ifb.conf_data_addr_ok;
  endfunction
  function automatic logic dok(input int d);
    return (d == 0) ? ifa.conf_data_data_ok : ifb.conf_data_data_ok;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? ifa.conf_data_rdata : ifb.conf_data_rdata;
  endfunction

  task automatic drive(input int d, input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      ifa.conf_data_req = req; ifa.conf_data_wr = wr; ifa.conf_data_size = size;
      ifa.conf_data_addr = addr; ifa.conf_data_wdata = wdata;
    end else begin
      ifb.conf_data_req = req; ifb.conf_data_wr = wr; ifb.conf_data_size = size;
      ifb.conf_data_addr = addr; ifb.conf_data_wdata = wdata;
    end
  endtask

  // Model: timer value seen during the interval after edge number c.
  function automatic logic [31:0] m_timer(input int d, input int unsigned c);
    return m_tbase[d] + (c - m_tcyc[d]);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] r = old;
    int lo, n;
    if (size == 2'b00) begin lo = addr % 4; n = 1; end
    else if (size == 2'b01) begin lo = ((addr % 4) / 2) * 2; n = 2; end
    else begin lo = 0; n = 4; end
    for (int i = lo; i < lo + n; i++) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_timer_read(input int d, input int unsigned c);
`ifdef CONF_TIMER_EN
    return m_timer(d, c);
`else
    return (d < 0) ? m_timer(d, c) : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] addr, input int unsigned acc);
    case ({addr[15:2], 2'b00})
      16'hF000: return {16'h0, m_led[d]};
      16'hF004: return {16'h0, sw};
      16'hF008: return m_num[d];
      16'hF00C: return m_scr[d];
      16'hE000: return m_timer_read(d, acc - 1);
      default:  return 32'h0;
    endcase
  endfunction

  task automatic m_write(input int d, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int unsigned acc);
    logic [31:0] t;
    case ({addr[15:2], 2'b00})
      16'hF000: begin t = lane_merge({16'h0, m_led[d]}, wdata, size, addr); m_led[d] = t[15:0]; end
      16'hF008: m_num[d] = lane_merge(m_num[d], wdata, size, addr);
      16'hF00C: m_scr[d] = lane_merge(m_scr[d], wdata, size, addr);
`ifdef CONF_TIMER_EN
      16'hE000: begin m_tbase[d] = lane_merge(m_timer(d, acc - 1), wdata, size, addr); m_tcyc[d] = acc; end
`endif
      default: ;
    endcase
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_led[d] = 16'h0; m_num[d] = 32'h0; m_scr[d] = 32'h0;
      m_tbase[d] = (d == 0) ? 32'h0 : 32'h0000_1000;
      m_tcyc[d] = cyc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    drive(1, 0, 0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_addr_ok", aok(d), 1);
      check("reset_data_ok", dok(d), 0);
      check("reset_rdata", rdat(d), 0);
    end
    check("reset_led", {led_b, led_a}, 0);
    check("reset_num_a", num_a, 0);
    check("reset_num_b", num_b, 0);
    rst = 1'b0;
    m_reset();
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic xact(input int d, input logic wr, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output int unsigned acc);
    int lat;
    logic [31:0] exp_rd;
    drive(d, 1, wr, size, addr, wdata);
    check("addr_ok_idle", aok(d), 1);
    @(negedge clk);
    acc = cyc;
    exp_rd = m_read(d, addr, acc);
    if (wr) m_write(d, size, addr, wdata, acc);
    lat = 1;
    while (!dok(d) && lat < 40) begin
      check("addr_ok_wait", aok(d), 0);
      @(negedge clk);
      lat++;
    end
    check("data_ok_latency", lat, (d == 0) ? 2 : 1);
    check("addr_ok_done", aok(d), 0);
    rd = rdat(d);
    if (!wr) check("rdata_model", rd, exp_rd);
    @(negedge clk);
    check("data_ok_single", dok(d), 0);
    check("addr_ok_after", aok(d), 1);
    drive(d, 0, 0, 2'b00, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] sw;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
    logic [31:0] exp_num;
  } vec_t;

  vec_t tab [18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int unsigned acc, acc_w;
    logic [31:0] r, addr;
    logic [15:0] bases [6];

    tab[0]  = '{1'b1, 2'b10, 32'h0000_F000, 32'h1234_ABCD, 16'h0,    1'b0, 32'h0,         16'hABCD, 32'h0};
    tab[1]  = '{1'b1, 2'b10, 32'h0000_F008, 32'h1122_3344, 16'h0,    1'b0, 32'h0,         16'hABCD, 32'h1122_3344};
    tab[2]  = '{1'b1, 2'b00, 32'h0000_F00A, 32'h00AB_0000, 16'h0,    1'b0, 32'h0,         16'hABCD, 32'h11AB_3344};
    tab[3]  = '{1'b0, 2'b10, 32'h0000_F008, 32'h0,         16'h0,    1'b1, 32'h11AB_3344, 16'hABCD, 32'h11AB_3344};
    tab[4]  = '{1'b1, 2'b01, 32'h0000_F001, 32'h0000_5566, 16'h0,    1'b0, 32'h0,         16'h5566, 32'h11AB_3344};
    tab[5]  = '{1'b1, 2'b01, 32'h0000_F002, 32'h7788_0000, 16'h0,    1'b0, 32'h0,         16'h5566, 32'h11AB_3344};
    tab[6]  = '{1'b0, 2'b00, 32'h0000_F000, 32'h0,         16'h0,    1'b1, 32'h0000_5566, 16'h5566, 32'h11AB_3344};
    tab[7]  = '{1'b0, 2'b00, 32'h0000_F004, 32'h0,         16'h5A5A, 1'b1, 32'h0000_5A5A, 16'h5566, 32'h11AB_3344};
    tab[8]  = '{1'b1, 2'b10, 32'h0000_F004, 32'hFFFF_FFFF, 16'h5A5A, 1'b0, 32'h0,         16'h5566, 32'h11AB_3344};
    tab[9]  = '{1'b1, 2'b00, 32'h0000_F00F, 32'hDE00_0000, 16'h0,    1'b0, 32'h0,         16'h5566, 32'h11AB_3344};
    tab[10] = '{1'b0, 2'b01, 32'h0000_F00E, 32'h0,         16'h0,    1'b1, 32'hDE00_0000, 16'h5566, 32'h11AB_3344};
    tab[11] = '{1'b1, 2'b10, 32'h0000_1234, 32'hFFFF_FFFF, 16'h0,    1'b0, 32'h0,         16'h5566, 32'h11AB_3344};
    tab[12] = '{1'b0, 2'b10, 32'h0000_1234, 32'h0,         16'h0,    1'b1, 32'h0,         16'h5566, 32'h11AB_3344};
    tab[13] = '{1'b0, 2'b10, 32'hABCD_F008, 32'h0,         16'h0,    1'b1, 32'h11AB_3344, 16'h5566, 32'h11AB_3344};
    tab[14] = '{1'b1, 2'b11, 32'h0000_F00C, 32'hCAFE_BABE, 16'h0,    1'b0, 32'h0,         16'h5566, 32'h11AB_3344};
    tab[15] = '{1'b0, 2'b00, 32'h0000_F00D, 32'h0,         16'h0,    1'b1, 32'hCAFE_BABE, 16'h5566, 32'h11AB_3344};
    tab[16] = '{1'b1, 2'b00, 32'h0000_F001, 32'h0000_9900, 16'h0,    1'b0, 32'h0,         16'h9966, 32'h11AB_3344};
    tab[17] = '{1'b0, 2'b10, 32'h0000_F000, 32'h0,         16'h0,    1'b1, 32'h0000_9966, 16'h9966, 32'h11AB_3344};

    bases = '{16'hF000, 16'hF004, 16'hF008, 16'hF00C, 16'hE000, 16'h1234};

    m_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      sw = tab[i].sw;
      xact(0, tab[i].wr, tab[i].size, tab[i].addr, tab[i].wdata, rd, acc);
      if (tab[i].chk_rd) check($sformatf("tab%0d_rdata", i), rd, tab[i].exp_rd);
      check($sformatf("tab%0d_led", i), led_a, tab[i].exp_led);
      check($sformatf("tab%0d_num", i), num_a, tab[i].exp_num);
    end

    // Timer: word write 0x100, read accepted six edges later sees 0x105.
    xact(0, 1'b1, 2'b10, 32'h0000_E000, 32'h0000_0100, rd, acc_w);
    repeat (3) @(negedge clk);
    xact(0, 1'b0, 2'b10, 32'h0000_E000, 32'h0, rd, acc);
    check("timer_spacing", acc - acc_w, 6);
`ifdef CONF_TIMER_EN
    check("timer_read", rd, 32'h0000_0105);
`else
    check("timer_read", rd, 32'h0);
`endif

    // RESP_LAT=1 instance: unmapped accesses complete next cycle and change nothing.
    xact(1, 1'b0, 2'b10, 32'h0000_1234, 32'h0, rd, acc);
    check("lat1_unmapped_rd", rd, 32'h0);
    xact(1, 1'b1, 2'b10, 32'h0000_1234, 32'hFFFF_FFFF, rd, acc);
    check("lat1_unmapped_led", led_b, 16'h0);
    check("lat1_unmapped_num", num_b, 32'h0);
    xact(1, 1'b0, 2'b10, 32'h0000_F00C, 32'h0, rd, acc);
    check("lat1_scratch_rd", rd, 32'h0);

    // Reset in WAIT of a SCRATCH write aborts the transaction.
    drive(0, 1, 1, 2'b10, 32'h0000_F00C, 32'h55AA_55AA);
    @(negedge clk);
    check("abort_in_wait", aok(0), 0);
    #2 rst = 1'b1;
    #1;
    check("abort_data_ok", dok(0), 0);
    check("abort_addr_ok", aok(0), 1);
    @(negedge clk);
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check("abort_no_data_ok", dok(0), 0);
      @(negedge clk);
    end
    rst = 1'b0;
    m_reset();
    check("abort_addr_ok_after", aok(0), 1);
    xact(0, 1'b0, 2'b10, 32'h0000_F00C, 32'h0, rd, acc);
    check("abort_scratch", rd, 32'h0);

    // Random traffic on both instances against the model.
    for (int n = 0; n < 200; n++) begin
      int d;
      logic [1:0] size;
      d = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = $urandom();
      sw = r[15:0];
      r = $urandom();
      addr = {r[31:16], bases[$urandom_range(0, 5)]};
      if ($urandom_range(0, 7) == 0) addr[15:0] = r[15:0];
      addr[1:0] = r[1:0];
      size = 2'($urandom_range(0, 3));
      xact(d, 1'($urandom_range(0, 1)), size, addr, $urandom(), rd, acc);
      check("rand_led", (d == 0) ? led_a : led_b, m_led[d]);
      check("rand_num", (d == 0) ? num_a : num_b, m_num[d]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
